// File: rtl/mem_arbiter_pkg.sv
// Shared types and default widths for the two-master memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    typedef logic master_t;

    localparam master_t MASTER0 = 1'b0;
    localparam master_t MASTER1 = 1'b1;

    localparam int DEF_ADDR_W    = 32;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_MAX_BURST = 16;

endpackage

// File: rtl/mem_arbiter_rdtrack.sv
// One-cycle pending-read tag: steers bus_rd back to the master whose read was
// accepted in the previous cycle.
module mem_arbiter_rdtrack
    import mem_arbiter_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_acc,
    input  master_t           rd_idx,
    input  logic [DATA_W-1:0] bus_rd,
    output logic              m0_rvalid,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m0_rd,
    output logic [DATA_W-1:0] m1_rd
);

    logic    vld_p1;
    master_t idx_p1;

    // Stage p1: the read accepted last cycle is answered now.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= rd_acc;
        end
    end

    always_ff @(posedge clk) begin
        idx_p1 <= rd_idx;
    end

    assign m0_rvalid = vld_p1 && (idx_p1 == MASTER0);
    assign m1_rvalid = vld_p1 && (idx_p1 == MASTER1);
    assign m0_rd     = m0_rvalid ? bus_rd : '0;
    assign m1_rd     = m1_rvalid ? bus_rd : '0;

endmodule

// File: rtl/mem_arbiter.sv
// Two-master bus arbiter. Define MEM_ARBITER_RR_EN for round-robin with a
// MAX_BURST forced release; otherwise m0 has fixed priority and may preempt m1.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wd,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wd,
    output logic              m0_gnt,
    output logic              m1_gnt,
    output logic              m0_rvalid,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m0_rd,
    output logic [DATA_W-1:0] m1_rd,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wd,
    input  logic [DATA_W-1:0] bus_rd
);

`ifdef MEM_ARBITER_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    localparam int               CNT_W      = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX  = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

    arb_state_t       state, state_nxt;
    logic [CNT_W-1:0] burst_cnt;
    master_t          last_srv;
    logic             pick0, rel0, rel1, any_gnt;

    // Release fires on the grant that completes the burst, so an owner gets
    // exactly MAX_BURST transfers while the other master waits.
    assign pick0 = !RR_EN || (last_srv == MASTER1);
    assign rel0  = RR_EN && (burst_cnt >= BURST_LAST);
    assign rel1  = RR_EN ? rel0 : 1'b1;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (m0_req && (!m1_req || pick0)) state_nxt = OWN0;
                else if (m1_req)                  state_nxt = OWN1;
            end
            OWN0: if (!m0_req || (m1_req && rel0)) state_nxt = m1_req ? OWN1 : IDLE;
            OWN1: if (!m1_req || (m0_req && rel1)) state_nxt = m0_req ? OWN0 : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            burst_cnt <= '0;
            last_srv  <= MASTER1;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)
                burst_cnt <= '0;
            else if (any_gnt && (burst_cnt != BURST_MAX))
                burst_cnt <= burst_cnt + 1'b1;
            if (m0_gnt)      last_srv <= MASTER0;
            else if (m1_gnt) last_srv <= MASTER1;
        end
    end

    assign m0_gnt  = m0_req && (state == OWN0);
    assign m1_gnt  = m1_req && (state == OWN1);
    assign any_gnt = m0_gnt || m1_gnt;

    assign bus_we   = m0_gnt ? m0_we   : (m1_gnt ? m1_we   : 1'b0);
    assign bus_addr = m0_gnt ? m0_addr : (m1_gnt ? m1_addr : '0);
    assign bus_wd   = m0_gnt ? m0_wd   : (m1_gnt ? m1_wd   : '0);

    mem_arbiter_rdtrack #(
        .DATA_W (DATA_W)
    ) u_rdtrack (
        .clk       (clk),
        .reset     (reset),
        .rd_acc    (any_gnt && !bus_we),
        .rd_idx    (m1_gnt ? MASTER1 : MASTER0),
        .bus_rd    (bus_rd),
        .m0_rvalid (m0_rvalid),
        .m1_rvalid (m1_rvalid),
        .m0_rd     (m0_rd),
        .m1_rd     (m1_rd)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed cycles push expected grants and
// read returns; a negedge monitor pops and compares whatever the DUT presents.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MB = 4;
`ifdef MEM_ARBITER_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr, bus_addr;
    logic [DW-1:0] m0_wd, m1_wd, bus_wd, m0_rd, m1_rd;
    logic [DW-1:0] bus_rd = '0;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, bus_we;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wd(m0_wd),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wd(m1_wd),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
        .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
        .m0_rd(m0_rd), .m1_rd(m1_rd),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_wd(bus_wd), .bus_rd(bus_rd)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        m;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
    } gexp_t;

    typedef struct {
        int          cyc;
        logic        m;
        logic [31:0] data;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];
    int    checks = 0;
    int    failures = 0;
    int    cyc_n = 0;

    function automatic logic [31:0] rd_of(input logic [31:0] a);
        return (a == 32'h0000_1004) ? 32'hDEAD_BEEF : {a[15:0], ~a[15:0]};
    endfunction

    // Interconnect model: read data follows the address by one cycle.
    always @(posedge clk) begin
        cyc_n  <= cyc_n + 1;
        bus_rd <= rd_of(bus_addr);
    end

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    task automatic check_idle(input string name);
        check(name, {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, bus_we, m0_rd, m1_rd, bus_addr, bus_wd}, '0);
    endtask

    gexp_t ge;
    rexp_t re;
    always @(negedge clk) begin
        if (!reset) begin
            if (m0_gnt || m1_gnt) begin
                if (gq.size() == 0) begin
                    check("unexpected_gnt", {cyc_n, m1_gnt, m0_gnt}, '0);
                end else begin
                    ge = gq.pop_front();
                    check("gnt", {cyc_n, m1_gnt, m0_gnt, bus_we, bus_addr, bus_wd},
                          {ge.cyc, ge.m, ~ge.m, ge.we, ge.addr, ge.wd});
                end
            end else begin
                check("idle_bus", {bus_we, bus_addr, bus_wd}, '0);
            end
            if (m0_rvalid || m1_rvalid) begin
                if (rq.size() == 0) begin
                    check("unexpected_rvalid", {cyc_n, m1_rvalid, m0_rvalid}, '0);
                end else begin
                    re = rq.pop_front();
                    check("rvalid", {cyc_n, m1_rvalid, m0_rvalid, m0_rd, m1_rd},
                          {re.cyc, re.m, ~re.m, re.m ? 32'h0 : re.data, re.m ? re.data : 32'h0});
                end
            end else begin
                check("idle_rd", {m0_rd, m1_rd}, '0);
            end
        end
    end

    // One cycle of stimulus; g names the master expected to be granted (-1: none).
    task automatic cyc(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                       input int g, input bit rd_ok = 1'b1);
        gexp_t e;
        rexp_t r;
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wd = d0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wd = d1;
        if (g >= 0) begin
            e.cyc  = cyc_n;
            e.m    = (g == 1);
            e.we   = (g == 1) ? w1 : w0;
            e.addr = (g == 1) ? a1 : a0;
            e.wd   = (g == 1) ? d1 : d0;
            gq.push_back(e);
            if (!e.we && rd_ok) begin
                r.cyc  = cyc_n + 1;
                r.m    = e.m;
                r.data = rd_of(e.addr);
                rq.push_back(r);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check_idle("rst_async");
        @(posedge clk);
        #1;
        check_idle("rst_hold");
        reset = 1'b0;
        #1;
        check_idle("rst_release");
        {m0_req, m0_we, m1_req, m1_we} = '0;
        m0_addr = '0; m0_wd = '0; m1_addr = '0; m1_wd = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_1004; m0_wd = '0;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0000_2000; m1_wd = '0;
        do_reset();

        // Lone read: grant one cycle after request, data the cycle after that.
        cyc(1, 0, 32'h0000_1004, 0, 0, 0, 0, 0, -1);
        cyc(1, 0, 32'h0000_1004, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, -1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, -1);

        // Simultaneous requests after reset: m0 first, m1 once m0 lets go.
        m0_req = 1'b1; m1_req = 1'b1;
        do_reset();
        cyc(1, 0, 32'h0000_0100, 0, 1, 0, 32'h0000_0200, 0, -1);
        cyc(1, 0, 32'h0000_0100, 0, 1, 0, 32'h0000_0200, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 32'h0000_0200, 0, -1);
        cyc(0, 0, 0, 0, 1, 0, 32'h0000_0200, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, -1);

        // Both held: RR hands over after MB grants, fixed priority never does.
        cyc(1, 0, 32'h0000_3000, 0, 1, 1, 32'h0000_2100, 32'hA5A5_0000, -1);
        for (int k = 0; k < 6; k++)
            cyc(1, 0, 32'h0000_3000 + 4 * k, 0, 1, 1, 32'h0000_2100, 32'hA5A5_0000 + k,
                (RR && k >= MB) ? 1 : 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, -1);

        // Lone write from m1.
        cyc(0, 0, 0, 0, 1, 1, 32'h0000_2000, 32'h1234_5678, -1);
        cyc(0, 0, 0, 0, 1, 1, 32'h0000_2000, 32'h1234_5678, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, -1);

        // m0 arrives while m1 owns: fixed priority preempts, RR waits for release.
        cyc(0, 0, 0, 0, 1, 0, 32'h0000_0040, 0, -1);
        cyc(0, 0, 0, 0, 1, 0, 32'h0000_0040, 0, 1);
        cyc(1, 0, 32'h0000_0050, 0, 1, 0, 32'h0000_0040, 0, 1);
        cyc(1, 0, 32'h0000_0050, 0, 1, 0, 32'h0000_0040, 0, RR ? 1 : 0);
        cyc(1, 0, 32'h0000_0050, 0, 0, 0, 0, 0, RR ? -1 : 0);
        cyc(1, 0, 32'h0000_0050, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, -1);

        // Reset right after an accepted read must swallow its rvalid.
        cyc(1, 0, 32'h0000_0060, 0, 0, 0, 0, 0, -1);
        cyc(1, 0, 32'h0000_0060, 0, 0, 0, 0, 0, 0, 1'b0);
        do_reset();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, -1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, -1);

        check("gnt_queue_left", gq.size(), 0);
        check("rd_queue_left", rq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
